// File: rtl/nf_ram_rmw_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : nf_ram_rmw_ctrl_if
// Brief    : Core data-port request/response bundle for nf_ram_rmw_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
interface nf_ram_rmw_ctrl_if;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_wd;
  logic        req_ack;
  logic        req_err;
  logic [31:0] req_rd;

  modport master (
    output req_valid, req_addr, req_we, req_size, req_unsigned, req_wd,
    input  req_ack, req_err, req_rd
  );

  modport slave (
    input  req_valid, req_addr, req_we, req_size, req_unsigned, req_wd,
    output req_ack, req_err, req_rd
  );
endinterface
`default_nettype wire

// File: rtl/nf_ram_rmw_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : nf_ram_rmw_ctrl
// Brief    : Byte/half/word load-store front end for a full-word-write RAM,
//            turning sub-word stores into read-modify-write sequences.
// Revision : 1.0 - initial release
// ============================================================================
module nf_ram_rmw_ctrl #(
  parameter int unsigned DEPTH = 64
) (
  input  wire logic          clk,
  input  wire logic          rst,
  nf_ram_rmw_ctrl_if.slave   req_if,
  output logic [31:0]        ram_addr_o,
  output logic               ram_we_o,
  output logic [31:0]        ram_wd_o,
  input  wire logic [31:0]   ram_rd_i
);

  localparam logic [29:0] c_depth = 30'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_MERGE  = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [31:0] wd_q, wd_d;
  logic        err_q, err_d;
  logic [31:0] rd_q, rd_d;
  logic [31:0] mrg_q, mrg_d;

  logic        w_req_err;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;
  logic [31:0] w_merge;
  logic        w_we;
  logic [31:0] w_wd;

  always_comb begin
    w_req_err = 1'b0;
    if (req_if.req_size == 2'b11) w_req_err = 1'b1;
    if (req_if.req_size == 2'b01 && req_if.req_addr[0]) w_req_err = 1'b1;
    if (req_if.req_size == 2'b10 && req_if.req_addr[1:0] != 2'b00) w_req_err = 1'b1;
    if (req_if.req_addr[31:2] >= c_depth) w_req_err = 1'b1;
  end

  always_comb begin
    w_byte = ram_rd_i[7:0];
    case (addr_q[1:0])
      2'd0:    w_byte = ram_rd_i[7:0];
      2'd1:    w_byte = ram_rd_i[15:8];
      2'd2:    w_byte = ram_rd_i[23:16];
      default: w_byte = ram_rd_i[31:24];
    endcase
    w_half = addr_q[1] ? ram_rd_i[31:16] : ram_rd_i[15:0];
    case (size_q)
      2'b00:   w_load = uns_q ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
      2'b01:   w_load = uns_q ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
      default: w_load = ram_rd_i;
    endcase
  end

  // Only the addressed lane of the previously read word is replaced.
  always_comb begin
    w_merge = mrg_q;
    if (size_q == 2'b00) begin
      case (addr_q[1:0])
        2'd0:    w_merge[7:0]   = wd_q[7:0];
        2'd1:    w_merge[15:8]  = wd_q[7:0];
        2'd2:    w_merge[23:16] = wd_q[7:0];
        default: w_merge[31:24] = wd_q[7:0];
      endcase
    end else if (addr_q[1]) begin
      w_merge[31:16] = wd_q[15:0];
    end else begin
      w_merge[15:0]  = wd_q[15:0];
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    wd_d    = wd_q;
    err_d   = err_q;
    rd_d    = rd_q;
    mrg_d   = mrg_q;
    w_we    = 1'b0;
    w_wd    = 32'h0;
    case (state_q)
      ST_IDLE: begin
        if (req_if.req_valid) begin
          addr_d = req_if.req_addr;
          we_d   = req_if.req_we;
          size_d = req_if.req_size;
          uns_d  = req_if.req_unsigned;
          wd_d   = req_if.req_wd;
          err_d  = w_req_err;
          if (w_req_err) begin
            rd_d    = 32'h0;
            state_d = ST_RESP;
          end else begin
            state_d = ST_ACCESS;
          end
        end
      end
      ST_ACCESS: begin
        if (!we_q) begin
          rd_d    = w_load;
          state_d = ST_RESP;
        end else if (size_q == 2'b10) begin
          w_we    = 1'b1;
          w_wd    = wd_q;
          rd_d    = 32'h0;
          state_d = ST_RESP;
        end else begin
          mrg_d   = ram_rd_i;
          state_d = ST_MERGE;
        end
      end
      ST_MERGE: begin
        w_we    = 1'b1;
        w_wd    = w_merge;
        rd_d    = 32'h0;
        state_d = ST_RESP;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= 32'h0;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      wd_q    <= 32'h0;
      err_q   <= 1'b0;
      rd_q    <= 32'h0;
      mrg_q   <= 32'h0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      wd_q    <= wd_d;
      err_q   <= err_d;
      rd_q    <= rd_d;
      mrg_q   <= mrg_d;
    end
  end

  // Reset gates the strobe combinationally so an aborted RMW never lands.
  assign ram_we_o       = w_we & ~rst;
  assign ram_wd_o       = w_wd;
  assign ram_addr_o     = {2'b00, addr_q[31:2]};
  assign req_if.req_ack = (state_q == ST_RESP);
  assign req_if.req_err = (state_q == ST_RESP) & err_q;
  assign req_if.req_rd  = rd_q;

endmodule
`default_nettype wire

// File: tb/tb_nf_ram_rmw_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_nf_ram_rmw_ctrl
// Brief    : Scoreboard bench for nf_ram_rmw_ctrl with a word-RAM model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nf_ram_rmw_ctrl;
  localparam int DEPTH = 64;

  typedef struct {
    logic        err;
    logic [31:0] rd;
    int          lat;
    int          nwr;
    int          wlat;
    logic [31:0] wdata;
    logic [31:0] widx;
    int          t;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] ram_addr, ram_wd, ram_rd;
  logic        ram_we;
  logic        init_mem = 1'b1;
  logic [31:0] mem   [DEPTH];
  logic [31:0] model [DEPTH];
  exp_t        exp_q [$];
  exp_t        mon_e;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          acks = 0;
  int          wr_cnt = 0;
  int          wr_lat = -1;
  logic [31:0] wr_data = 32'h0;
  logic [31:0] wr_idx = 32'h0;

  always #5 clk = ~clk;

  nf_ram_rmw_ctrl_if req_if ();

  nf_ram_rmw_ctrl #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_if     (req_if),
    .ram_addr_o (ram_addr),
    .ram_we_o   (ram_we),
    .ram_wd_o   (ram_wd),
    .ram_rd_i   (ram_rd)
  );

  function automatic logic [31:0] seed(input int i);
    return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (init_mem) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= seed(i);
    end else if (ram_we && ram_addr < 32'(DEPTH)) begin
      mem[ram_addr[5:0]] <= ram_wd;
    end
  end

  assign ram_rd = (ram_addr < 32'(DEPTH)) ? mem[ram_addr[5:0]] : 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: records RAM writes and scores every ack against the queue.
  initial begin
    forever begin
      @(negedge clk);
      if (ram_we) begin
        wr_cnt++;
        wr_data = ram_wd;
        wr_idx  = ram_addr;
        wr_lat  = (exp_q.size() > 0) ? cyc - exp_q[0].t : -1;
      end
      if (req_if.req_ack) begin
        acks++;
        if (exp_q.size() == 0) begin
          chk("unexpected_ack", 32'd1, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("req_err", {31'h0, req_if.req_err}, {31'h0, mon_e.err});
          chk("req_rd", req_if.req_rd, mon_e.rd);
          chk("ack_latency", 32'(cyc - mon_e.t), 32'(mon_e.lat));
          chk("write_count", 32'(wr_cnt), 32'(mon_e.nwr));
          chk("we_in_resp", {31'h0, ram_we}, 32'h0);
          if (mon_e.nwr != 0) begin
            chk("write_cycle", 32'(wr_lat), 32'(mon_e.wlat));
            chk("write_data", wr_data, mon_e.wdata);
            chk("write_index", wr_idx, mon_e.widx);
          end
        end
        wr_cnt = 0;
      end
    end
  end

  // Reference behaviour: lane selection by shift and mask on a shadow word array.
  task automatic issue(input logic [31:0] a, input logic we, input logic [1:0] sz,
                       input logic uns, input logic [31:0] wd, input int toff, input bit track);
    exp_t        e;
    logic [31:0] w, mask, v;
    int          sh;
    e.err   = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00)
              || ({2'b00, a[31:2]} >= 32'(DEPTH));
    e.rd    = 32'h0;
    e.nwr   = 0;
    e.wlat  = -1;
    e.wdata = 32'h0;
    e.widx  = 32'h0;
    e.t     = cyc + toff;
    e.lat   = 1;
    if (!e.err) begin
      sh   = 8 * int'(a[1:0]);
      w    = model[a[7:2]];
      mask = (sz == 2'b00) ? 32'h0000_00FF : (sz == 2'b01) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
      mask = mask << sh;
      if (!we) begin
        v = (w & mask) >> sh;
        if (!uns && sz == 2'b00 && v[7])  v = v | 32'hFFFF_FF00;
        if (!uns && sz == 2'b01 && v[15]) v = v | 32'hFFFF_0000;
        e.rd  = v;
        e.lat = 2;
      end else begin
        v       = (w & ~mask) | ((wd << sh) & mask);
        e.nwr   = 1;
        e.wdata = v;
        e.widx  = {2'b00, a[31:2]};
        e.lat   = (sz == 2'b10) ? 2 : 3;
        e.wlat  = e.lat - 1;
        if (track) model[a[7:2]] = v;
      end
    end
    if (track) exp_q.push_back(e);
    wr_cnt                = 0;
    req_if.req_addr       = a;
    req_if.req_we         = we;
    req_if.req_size       = sz;
    req_if.req_unsigned   = uns;
    req_if.req_wd         = wd;
    req_if.req_valid      = 1'b1;
  endtask

  task automatic finish_req(input bit hold, output int acyc);
    @(posedge clk);
    @(negedge clk);
    if (!hold) req_if.req_valid = 1'b0;
    acyc = -1;
    for (int k = 0; k < 12; k++) begin
      if (req_if.req_ack) begin
        acyc = cyc;
        break;
      end
      @(negedge clk);
    end
    if (acyc < 0) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout actual=none required=ack within 12 cycles");
      exp_q.delete();
      req_if.req_valid = 1'b0;
    end
  endtask

  task automatic do_req(input logic [31:0] a, input logic we, input logic [1:0] sz,
                        input logic uns, input logic [31:0] wd);
    int ac;
    @(negedge clk);
    issue(a, we, sz, uns, wd, 0, 1'b1);
    finish_req(1'b0, ac);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ack"},  {31'h0, req_if.req_ack}, 32'h0);
    chk({tag, "_err"},  {31'h0, req_if.req_err}, 32'h0);
    chk({tag, "_rd"},   req_if.req_rd, 32'h0);
    chk({tag, "_we"},   {31'h0, ram_we}, 32'h0);
    chk({tag, "_addr"}, ram_addr, 32'h0);
    chk({tag, "_wd"},   ram_wd, 32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ra, rb, a0;
    logic [31:0] a;
    logic [1:0]  sz;
    req_if.req_valid    = 1'b0;
    req_if.req_addr     = 32'h0;
    req_if.req_we       = 1'b0;
    req_if.req_size     = 2'b00;
    req_if.req_unsigned = 1'b0;
    req_if.req_wd       = 32'h0;
    for (int i = 0; i < DEPTH; i++) model[i] = seed(i);
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst      = 1'b0;
    init_mem = 1'b0;

    do_req(32'h10, 1'b1, 2'b10, 1'b0, 32'hDEADBEEF);
    do_req(32'h10, 1'b0, 2'b10, 1'b0, 32'h0);

    do_req(32'h10, 1'b1, 2'b10, 1'b0, 32'h11223344);
    do_req(32'h12, 1'b1, 2'b00, 1'b0, 32'h5555_55AB);
    do_req(32'h10, 1'b0, 2'b10, 1'b0, 32'h0);

    do_req(32'h10, 1'b1, 2'b10, 1'b0, 32'h8001_7F00);
    do_req(32'h12, 1'b0, 2'b01, 1'b0, 32'h0);
    do_req(32'h12, 1'b0, 2'b01, 1'b1, 32'h0);
    do_req(32'h11, 1'b0, 2'b00, 1'b0, 32'h0);

    do_req(32'h11,  1'b1, 2'b01, 1'b0, 32'h1234);
    do_req(32'h02,  1'b0, 2'b10, 1'b0, 32'h0);
    do_req(32'h00,  1'b0, 2'b11, 1'b0, 32'h0);
    do_req(32'h100, 1'b0, 2'b10, 1'b0, 32'h0);

    // Abort a byte store while it sits in its merge cycle.
    @(negedge clk);
    issue(32'h10, 1'b1, 2'b00, 1'b0, 32'hCD, 0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    req_if.req_valid = 1'b0;
    @(negedge clk);
    chk("merge_we_before_rst", {31'h0, ram_we}, 32'h1);
    a0  = acks;
    rst = 1'b1;
    #1;
    chk("rst_forces_we_low", {31'h0, ram_we}, 32'h0);
    @(negedge clk);
    chk_reset_outputs("abort");
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("no_ack_after_abort", 32'(acks), 32'(a0));
    do_req(32'h10, 1'b0, 2'b10, 1'b0, 32'h0);

    @(negedge clk);
    issue(32'h00, 1'b0, 2'b10, 1'b0, 32'h0, 0, 1'b1);
    finish_req(1'b1, ra);
    issue(32'h04, 1'b0, 2'b10, 1'b0, 32'h0, 1, 1'b1);
    @(negedge clk);
    finish_req(1'b0, rb);
    chk("b2b_ack_spacing", 32'(rb - ra), 32'd3);

    for (int n = 0; n < 200; n++) begin
      a  = 32'($urandom_range(0, DEPTH * 4 + 7));
      if ($urandom_range(0, 15) == 0) a = $urandom;
      sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'b01) a[0] = 1'b0;
        if (sz == 2'b10) a[1:0] = 2'b00;
      end
      do_req(a, 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), $urandom);
    end

    repeat (2) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    for (int i = 0; i < DEPTH; i++) chk("ram_final", mem[i], model[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
